// File: rtl/vector_acc_readout.sv
// Ping-pong capture of accumulated vectors with ready/valid replay.
// Each frame gets index/last markers; frames that find no free bank are dropped whole and counted.
module vector_acc_readout #(
    parameter int DIN_WIDTH  = 64,
    parameter int VECTOR_LEN = 64,
    parameter int DROP_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIN_WIDTH-1:0]          din,
    input  logic                          din_valid,
    output logic [DIN_WIDTH-1:0]          dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(VECTOR_LEN)-1:0] dout_index,
    output logic                          dout_last,
    output logic                          frame_drop,
    output logic [DROP_WIDTH-1:0]         drop_count
);

    localparam int IW = $clog2(VECTOR_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(VECTOR_LEN - 1);

    typedef enum logic {IDLE, STREAM} rd_state_t;

    logic [DIN_WIDTH-1:0] mem [2*VECTOR_LEN];

    logic [IW-1:0] w_idx;
    logic          wb;
    logic          w_drop;
    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic          w_first, w_last, bank_free, frame_ok, wr_en;

    rd_state_t     rd_state, rd_state_nxt;
    logic [IW-1:0] r_idx;
    logic          rb;
    logic          vld_p0;
    logic          space_ok;

    logic [DIN_WIDTH-1:0] data_p1;
    logic [IW-1:0]        idx_p1;
    logic                 bank_p1;
    logic                 vld_p1;

    logic [DIN_WIDTH-1:0] ent_data_p2 [2];
    logic [IW-1:0]        ent_idx_p2  [2];
    logic                 ent_bank_p2 [2];
    logic                 wptr, rptr;
    logic [1:0]           cnt;
    logic                 pop, rel, rel_bank;

    // ---- write side: frame admission and bank bookkeeping
    assign w_first   = (w_idx == '0);
    assign w_last    = (w_idx == LAST_IDX);
    // A bank released by the reader in this very cycle counts as free.
    assign bank_free = ~full[wb] | (rel & (rel_bank == wb));
    assign frame_ok  = w_first ? bank_free : ~w_drop;
    assign wr_en     = din_valid & frame_ok;

    always_comb begin
        full_nxt = full;
        if (rel)
            full_nxt[rel_bank] = 1'b0;
        if (din_valid && w_last && frame_ok)
            full_nxt[wb] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_idx      <= '0;
            wb         <= 1'b0;
            w_drop     <= 1'b0;
            full       <= 2'b00;
            frame_drop <= 1'b0;
            drop_count <= '0;
        end else begin
            frame_drop <= 1'b0;
            full       <= full_nxt;
            if (din_valid) begin
                w_idx <= w_idx + IW'(1);
                if (w_first)
                    w_drop <= ~bank_free;
                if (w_last) begin
                    if (frame_ok) begin
                        wb <= ~wb;
                    end else begin
                        frame_drop <= 1'b1;
                        if (drop_count != '1)
                            drop_count <= drop_count + DROP_WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wb, w_idx}] <= din;
    end

    // ---- p0: read issue, throttled so p1 plus the output buffer never exceed two words
    assign pop      = dout_valid & dout_ready;
    assign space_ok = ({1'b0, cnt} + {2'b00, vld_p1}) < (3'd2 + {2'b00, pop});

    always_comb begin
        rd_state_nxt = rd_state;
        vld_p0       = 1'b0;
        case (rd_state)
            IDLE: begin
                if (full[rb] && space_ok) begin
                    vld_p0       = 1'b1;
                    rd_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (space_ok) begin
                    vld_p0 = 1'b1;
                    if (r_idx == LAST_IDX)
                        rd_state_nxt = IDLE;
                end
            end
            default: rd_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= IDLE;
            r_idx    <= '0;
            rb       <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            rd_state <= rd_state_nxt;
            vld_p1   <= vld_p0;
            if (vld_p0) begin
                r_idx <= r_idx + IW'(1);
                if (r_idx == LAST_IDX)
                    rb <= ~rb;
            end
        end
    end

    // ---- p1: synchronous bank read
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            data_p1 <= mem[{rb, r_idx}];
            idx_p1  <= r_idx;
            bank_p1 <= rb;
        end
    end

    // ---- p2: two-entry output buffer (holding register plus skid)
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (vld_p1)
                wptr <= ~wptr;
            if (pop)
                rptr <= ~rptr;
            cnt <= cnt + {1'b0, vld_p1} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            ent_data_p2[wptr] <= data_p1;
            ent_idx_p2[wptr]  <= idx_p1;
            ent_bank_p2[wptr] <= bank_p1;
        end
    end

    assign dout_valid = (cnt != 2'd0);
    assign dout       = dout_valid ? ent_data_p2[rptr] : '0;
    assign dout_index = dout_valid ? ent_idx_p2[rptr] : '0;
    assign dout_last  = dout_valid & (ent_idx_p2[rptr] == LAST_IDX);
    assign rel        = pop & dout_last;
    assign rel_bank   = ent_bank_p2[rptr];

endmodule
